// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Programmable raster timing generator on clk_vid. Emits pixel enable, active
//   video, syncs and field flag. Timing is held in a shadow register set that can
//   be written at any time; a commit request applies the shadow set at the next
//   frame boundary and toggles new_vmode so software re-reads the mode.
// Ports
//   clk_vid     video clock
//   reset       asynchronous, active-high reset
//   cfg_wr      shadow register write strobe
//   cfg_addr    0 HACT,1 HFP,2 HSW,3 HBP,4 VACT,5 VFP,6 VSW,7 VBP,8 INTERLACE(bit0)
//   cfg_data    write data (addresses 9-15 ignored)
//   cfg_commit  request to apply the shadow set at the next frame boundary
//   ce_pix      pixel clock enable, one pulse every CE_DIV clocks
//   de,hs,vs    active video, horizontal sync, vertical sync (active-high)
//   f1          field flag (1 = odd interlaced field)
//   hcnt,vcnt   pixel / line position the other outputs refer to
//   new_vmode   toggles once per applied commit
//   busy        commit pending
module video_timing_gen #(
    parameter int unsigned CE_DIV = 1,
    parameter int unsigned HACT   = 640,
    parameter int unsigned HFP    = 16,
    parameter int unsigned HSW    = 96,
    parameter int unsigned HBP    = 48,
    parameter int unsigned VACT   = 480,
    parameter int unsigned VFP    = 10,
    parameter int unsigned VSW    = 2,
    parameter int unsigned VBP    = 33
) (
    input  logic        clk_vid,
    input  logic        reset,
    input  logic        cfg_wr,
    input  logic [3:0]  cfg_addr,
    input  logic [11:0] cfg_data,
    input  logic        cfg_commit,
    output logic        ce_pix,
    output logic        de,
    output logic        hs,
    output logic        vs,
    output logic        f1,
    output logic [11:0] hcnt,
    output logic [11:0] vcnt,
    output logic        new_vmode,
    output logic        busy
);

    typedef struct packed {
        logic [11:0] hact;
        logic [11:0] hfp;
        logic [11:0] hsw;
        logic [11:0] hbp;
        logic [11:0] vact;
        logic [11:0] vfp;
        logic [11:0] vsw;
        logic [11:0] vbp;
        logic        il;
    } timing_t;

    localparam timing_t DEFAULTS = '{
        hact: 12'(HACT), hfp: 12'(HFP), hsw: 12'(HSW), hbp: 12'(HBP),
        vact: 12'(VACT), vfp: 12'(VFP), vsw: 12'(VSW), vbp: 12'(VBP),
        il: 1'b0
    };
    localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t      state;
    timing_t     shadow;
    timing_t     act;
    logic [3:0]  div;
    logic [3:0]  div_nxt;
    logic [12:0] h;
    logic [12:0] v;
    logic        fld;

    logic [12:0] htot, vtot, htot_eff, vtot_eff, v_last_idx;
    logic [12:0] hs_beg, hs_end, vs_beg, vs_end, half;
    logic        h_last, v_last, boundary, apply;
    logic        de_n, hs_n, vs_n, vs_after, vs_before;

    // Pixel divider; ce_pix is registered so it is 0 while in reset.
    assign div_nxt = (div == DIV_LAST) ? '0 : div + 4'd1;

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            div    <= '0;
            ce_pix <= 1'b0;
        end else begin
            div    <= div_nxt;
            ce_pix <= (div_nxt == DIV_LAST);
        end
    end

    always_comb begin
        htot     = 13'(act.hact) + 13'(act.hfp) + 13'(act.hsw) + 13'(act.hbp);
        vtot     = 13'(act.vact) + 13'(act.vfp) + 13'(act.vsw) + 13'(act.vbp);
        // A zero total would otherwise leave no valid last position.
        htot_eff = (htot == '0) ? 13'd1 : htot;
        vtot_eff = (vtot == '0) ? 13'd1 : vtot;
        // Odd field carries one extra blank line.
        v_last_idx = vtot_eff + 13'(fld) - 13'd1;

        h_last   = (h >= htot_eff - 13'd1);
        v_last   = (v >= v_last_idx);
        boundary = ce_pix && h_last && v_last;
        apply    = boundary && (state == PEND);

        hs_beg = 13'(act.hact) + 13'(act.hfp);
        hs_end = hs_beg + 13'(act.hsw);
        vs_beg = 13'(act.vact) + 13'(act.vfp);
        vs_end = vs_beg + 13'(act.vsw);
        half   = htot_eff >> 1;

        de_n = (h < 13'(act.hact)) && (v < 13'(act.vact));
        hs_n = (h >= hs_beg) && (h < hs_end);

        // Odd field: window spans (vs_beg, half) .. (vs_end, half) in raster order.
        vs_after  = (v > vs_beg) || ((v == vs_beg) && (h >= half));
        vs_before = (v < vs_end) || ((v == vs_end) && (h < half));
        vs_n = (act.vsw != '0) &&
               (fld ? (vs_after && vs_before) : ((v >= vs_beg) && (v < vs_end)));
    end

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            h    <= '0;
            v    <= '0;
            fld  <= 1'b0;
            de   <= 1'b0;
            hs   <= 1'b0;
            vs   <= 1'b0;
            f1   <= 1'b0;
            hcnt <= '0;
            vcnt <= '0;
        end else if (ce_pix) begin
            de   <= de_n;
            hs   <= hs_n;
            vs   <= vs_n;
            f1   <= fld;
            hcnt <= h[11:0];
            vcnt <= v[11:0];
            if (h_last) begin
                h <= '0;
                if (v_last) begin
                    v <= '0;
                    if (apply)
                        fld <= 1'b0;
                    else
                        fld <= act.il ? ~fld : 1'b0;
                end else begin
                    v <= v + 13'd1;
                end
            end else begin
                h <= h + 13'd1;
            end
        end
    end

    // Commit FSM plus shadow/active sets. A write in the apply cycle lands in
    // shadow only, since act samples the pre-write shadow value.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            new_vmode <= 1'b0;
            shadow    <= DEFAULTS;
            act       <= DEFAULTS;
        end else begin
            if (cfg_wr) begin
                case (cfg_addr)
                    4'd0: shadow.hact <= cfg_data;
                    4'd1: shadow.hfp  <= cfg_data;
                    4'd2: shadow.hsw  <= cfg_data;
                    4'd3: shadow.hbp  <= cfg_data;
                    4'd4: shadow.vact <= cfg_data;
                    4'd5: shadow.vfp  <= cfg_data;
                    4'd6: shadow.vsw  <= cfg_data;
                    4'd7: shadow.vbp  <= cfg_data;
                    4'd8: shadow.il   <= cfg_data[0];
                    default: ;
                endcase
            end
            case (state)
                IDLE: begin
                    if (cfg_commit) begin
                        state <= PEND;
                        busy  <= 1'b1;
                    end
                end
                PEND: begin
                    if (apply) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        act       <= shadow;
                        new_vmode <= ~new_vmode;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    localparam int CE = 2;
    localparam int P[9] = '{8, 2, 2, 4, 4, 1, 1, 2, 0};

    logic        clk_vid = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [11:0] cfg_data = '0;
    logic        cfg_commit = 1'b0;
    logic        ce_pix, de, hs, vs, f1, new_vmode, busy;
    logic [11:0] hcnt, vcnt;

    logic        ce1, de1, hs1, vs1, f11, nv1, busy1;
    logic [11:0] hcnt1, vcnt1;
    logic        tie_wr = 1'b0;
    logic        tie_commit = 1'b0;
    logic [3:0]  tie_addr = '0;
    logic [11:0] tie_data = '0;

    video_timing_gen #(.CE_DIV(CE), .HACT(8), .HFP(2), .HSW(2), .HBP(4),
                       .VACT(4), .VFP(1), .VSW(1), .VBP(2)) dut (
        .clk_vid(clk_vid), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_commit(cfg_commit), .ce_pix(ce_pix), .de(de),
        .hs(hs), .vs(vs), .f1(f1), .hcnt(hcnt), .vcnt(vcnt),
        .new_vmode(new_vmode), .busy(busy));

    video_timing_gen #(.CE_DIV(1)) dut1 (
        .clk_vid(clk_vid), .reset(reset), .cfg_wr(tie_wr), .cfg_addr(tie_addr),
        .cfg_data(tie_data), .cfg_commit(tie_commit), .ce_pix(ce1), .de(de1),
        .hs(hs1), .vs(vs1), .f1(f11), .hcnt(hcnt1), .vcnt(vcnt1),
        .new_vmode(nv1), .busy(busy1));

    always #5 clk_vid = ~clk_vid;

    int checks = 0;
    int errors = 0;

    // Reference model: position is a linear pixel index within the field.
    int   m_set[9];
    int   s_set[9];
    int   m_p, m_n, m_tog;
    bit   m_f1, m_pend, m_ce;
    logic e_de, e_hs, e_vs, e_f1;
    int   e_h, e_v;

    int   cyc, de_max, hs_cnt, de_cnt, vm_changes;
    logic prev_vs, prev_vm;
    int   q_t[$];
    int   q_h[$];
    int   q_f[$];

    function automatic int eff(input int s);
        int t;
        t = s % 8192;
        return (t == 0) ? 1 : t;
    endfunction
    function automatic int ht();
        return eff(m_set[0] + m_set[1] + m_set[2] + m_set[3]);
    endfunction
    function automatic int vt();
        return eff(m_set[4] + m_set[5] + m_set[6] + m_set[7]);
    endfunction
    function automatic int flen();
        return ht() * (vt() + int'(m_f1));
    endfunction

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_set[i] = P[i];
            s_set[i] = P[i];
        end
        m_p = 0; m_n = 0; m_tog = 0;
        m_f1 = 1'b0; m_pend = 1'b0; m_ce = 1'b0;
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_f1 = 1'b0; e_h = 0; e_v = 0;
    endtask

    task automatic model_edge(input bit wr, input int addr, input int data, input bit commit);
        bit old_pend;
        bit bnd;
        int h, v, hw, st;
        old_pend = m_pend;
        bnd = 1'b0;
        if (m_ce) begin
            hw = ht();
            h = m_p % hw;
            v = m_p / hw;
            e_h = h; e_v = v; e_f1 = m_f1;
            e_de = (h < m_set[0]) && (v < m_set[4]);
            e_hs = (h >= m_set[0] + m_set[1]) && (h < m_set[0] + m_set[1] + m_set[2]);
            st = m_set[4] + m_set[5];
            if (!m_f1) begin
                e_vs = (v >= st) && (v < st + m_set[6]);
            end else begin
                st = st * hw + hw / 2;
                e_vs = (m_p >= st) && (m_p < st + m_set[6] * hw);
            end
            if (m_p == flen() - 1) begin
                bnd = 1'b1;
                m_p = 0;
                if (old_pend) begin
                    m_set = s_set;
                    m_tog++;
                    m_f1 = 1'b0;
                end else begin
                    m_f1 = (m_set[8] != 0) ? ~m_f1 : 1'b0;
                end
            end else begin
                m_p++;
            end
        end
        if (old_pend && bnd) m_pend = 1'b0;
        else if (!old_pend && commit) m_pend = 1'b1;
        if (wr && addr <= 8) s_set[addr] = (addr == 8) ? (data & 1) : data;
        m_n++;
        m_ce = ((m_n % CE) == CE - 1);
    endtask

    task automatic compare_all();
        chk("ce_pix", ce_pix, m_ce);
        chk("de", de, e_de);
        chk("hs", hs, e_hs);
        chk("vs", vs, e_vs);
        chk("f1", f1, e_f1);
        chk("hcnt", hcnt, e_h);
        chk("vcnt", vcnt, e_v);
        chk("busy", busy, m_pend);
        chk("new_vmode", new_vmode, m_tog % 2);
    endtask

    task automatic tick_io(input bit wr, input logic [3:0] addr, input logic [11:0] data,
                           input bit commit);
        cfg_wr = wr; cfg_addr = addr; cfg_data = data; cfg_commit = commit;
        @(posedge clk_vid);
        model_edge(wr, int'(addr), int'(data), commit);
        #1;
        cfg_wr = 1'b0; cfg_commit = 1'b0;
        compare_all();
        cyc++;
        if (vs === 1'b1 && prev_vs === 1'b0) begin
            q_t.push_back(cyc);
            q_h.push_back(int'(hcnt));
            q_f.push_back(int'(f1));
        end
        if (de === 1'b1 && int'(hcnt) > de_max) de_max = int'(hcnt);
        if (hs === 1'b1) hs_cnt++;
        if (de === 1'b1) de_cnt++;
        if (new_vmode !== prev_vm) vm_changes++;
        prev_vs = vs;
        prev_vm = new_vmode;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick_io(1'b0, 4'd0, 12'd0, 1'b0);
    endtask

    task automatic wait_idle(input int limit, output int waited);
        waited = 0;
        while (busy !== 1'b0 && waited < limit) begin
            run(1);
            waited++;
        end
        chk("busy_clear", busy, 1'b0);
    endtask

    task automatic clear_stats();
        q_t.delete(); q_h.delete(); q_f.delete();
        de_max = -1; hs_cnt = 0; de_cnt = 0; vm_changes = 0;
    endtask

    initial begin
        int w, k;
        cyc = 0; prev_vs = 1'b0; prev_vm = 1'b0;
        clear_stats();
        model_reset();

        // Reset state
        reset = 1'b1;
        #17;
        compare_all();
        @(negedge clk_vid);
        reset = 1'b0;

        // Progressive frame with parameter timing
        run(600);
        chk("p1_rises", q_t.size() >= 2, 1'b1);
        if (q_t.size() >= 2) begin
            chk("p1_frame_clk", 13'(q_t[1] - q_t[0]), 13'd256);
            chk("p1_vs_hcnt", 13'(q_h[0]), 13'd0);
        end
        chk("p1_de_width", 13'(de_max + 1), 13'd8);

        // Interlace
        tick_io(1'b1, 4'd8, 12'd1, 1'b0);
        tick_io(1'b0, 4'd0, 12'd0, 1'b1);
        wait_idle(1000, w);
        clear_stats();
        run(1500);
        chk("p2_rises", q_t.size() >= 5, 1'b1);
        if (q_t.size() >= 5) begin
            for (int i = 0; i < 4; i++) begin
                chk("p2_f1_alt", 13'(q_f[i]), 13'(i % 2));
                chk("p2_vs_hcnt", 13'(q_h[i]), (i % 2 == 1) ? 13'd8 : 13'd0);
                chk("p2_rise_gap", 13'(q_t[i + 1] - q_t[i]), 13'd272);
            end
            chk("p2_two_field", 13'(q_t[2] - q_t[0]), 13'd544);
        end

        // Mid-frame HACT=12 with interlace off, then commit
        run(37);
        tick_io(1'b1, 4'd8, 12'd0, 1'b0);
        tick_io(1'b1, 4'd0, 12'd12, 1'b0);
        clear_stats();
        tick_io(1'b0, 4'd0, 12'd0, 1'b1);
        chk("p3_busy", busy, 1'b1);
        wait_idle(1000, w);
        de_max = -1;
        run(700);
        chk("p3_de_width", 13'(de_max + 1), 13'd12);
        chk("p3_one_toggle", 13'(vm_changes), 13'd1);

        // Three commits in one frame
        k = 0;
        while (!(m_ce && m_p == 0) && k < 1000) begin run(1); k++; end
        clear_stats();
        tick_io(1'b0, 4'd0, 12'd0, 1'b1);
        run(20);
        tick_io(1'b0, 4'd0, 12'd0, 1'b1);
        run(20);
        tick_io(1'b0, 4'd0, 12'd0, 1'b1);
        wait_idle(1000, w);
        run(400);
        chk("p4_one_toggle", 13'(vm_changes), 13'd1);

        // Commit coincident with frame boundary
        k = 0;
        while (!(m_ce && m_p == flen() - 1 && !m_pend) && k < 1000) begin run(1); k++; end
        clear_stats();
        tick_io(1'b0, 4'd0, 12'd0, 1'b1);
        chk("p4_coinc_busy", busy, 1'b1);
        chk("p4_coinc_no_toggle", 13'(vm_changes), 13'd0);
        wait_idle(1000, w);
        chk("p4_defer_clk", 13'(w), 13'd320);
        chk("p4_coinc_toggle", 13'(vm_changes), 13'd1);

        // Reset at hcnt=5, vcnt=2 with commit pending
        k = 0;
        while (!(m_ce && m_p == 0) && k < 1000) begin run(1); k++; end
        tick_io(1'b1, 4'd0, 12'd4, 1'b0);
        tick_io(1'b0, 4'd0, 12'd0, 1'b1);
        k = 0;
        while (!(hcnt === 12'd5 && vcnt === 12'd2) && k < 2000) begin run(1); k++; end
        chk("p5_reached", (hcnt === 12'd5 && vcnt === 12'd2), 1'b1);
        chk("p5_pending", busy, 1'b1);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk_vid);
        reset = 1'b0;
        prev_vs = 1'b0; prev_vm = 1'b0;
        clear_stats();
        run(600);
        chk("p5_busy_after", busy, 1'b0);
        chk("p5_rises", q_t.size() >= 2, 1'b1);
        if (q_t.size() >= 2) chk("p5_frame_clk", 13'(q_t[1] - q_t[0]), 13'd256);
        chk("p5_de_width", 13'(de_max + 1), 13'd8);

        // HSW=0
        tick_io(1'b1, 4'd2, 12'd0, 1'b0);
        tick_io(1'b0, 4'd0, 12'd0, 1'b1);
        wait_idle(1000, w);
        clear_stats();
        run(400);
        chk("p6_hs_never", 13'(hs_cnt), 13'd0);

        // VACT=0
        tick_io(1'b1, 4'd4, 12'd0, 1'b0);
        tick_io(1'b0, 4'd0, 12'd0, 1'b1);
        wait_idle(1000, w);
        clear_stats();
        run(600);
        chk("p6_de_never", 13'(de_cnt), 13'd0);
        chk("p6_wraps", q_t.size() >= 4, 1'b1);
        if (q_t.size() >= 2) chk("p6_frame_clk", 13'(q_t[1] - q_t[0]), 13'd112);

        // CE_DIV=1
        for (int i = 0; i < 20; i++) begin
            run(1);
            chk("ce_div1_const", ce1, 1'b1);
        end

        // Randomized configuration traffic
        for (int i = 0; i < 4000; i++) begin
            bit          wr, cm;
            logic [3:0]  a;
            logic [11:0] d;
            wr = ($urandom_range(0, 7) == 0);
            cm = ($urandom_range(0, 39) == 0);
            a  = 4'($urandom_range(0, 15));
            d  = (a < 4'd8) ? 12'($urandom_range(0, 9)) : 12'($urandom_range(0, 4095));
            tick_io(wr, a, d, cm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
